// File: rtl/fir_seq_pkg.sv
// Shared definitions for the FIR control sequencer.
//   seq_state_t  : sequencer FSM states (load burst and read/MAC sweep)
//   LD_GAP_LEN   : idle cycles at the start of each bank load
//   LD_TAIL_LEN  : idle cycles after each bank's coefficient burst
//   RD_TAIL_LEN  : idle cycles closing a read sweep
//   ROM_LAT      : coefficient ROM read latency in clocks
package fir_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_GAP,
    LD_ARM,
    LD_DATA,
    LD_TAIL,
    RD_FIRST,
    RD_TAPS,
    RD_TAIL
  } seq_state_t;

  localparam int LD_GAP_LEN  = 4;
  localparam int LD_TAIL_LEN = 5;
  localparam int RD_TAIL_LEN = 9;
  localparam int ROM_LAT     = 1;

endpackage

// File: rtl/fir_ctrl_sequencer.sv
// FIR control sequencer: loads NUM_BANKS x NUM_TAPS coefficients from a
// synchronous ROM into the filter after iLoadStart, then runs one read/MAC
// sweep per accepted 600 kHz sample strobe on the selected bank.
// Ports:
//   iClk12M, iRst        : clock, synchronous active-high reset
//   iLoadStart           : start full coefficient load (IDLE only)
//   iEnSample600k        : sample strobe; iSample/iBankSel captured on accept
//   iCoefData/oCoefAddr  : ROM read port (data one cycle after address)
//   oCoeffUpdateFlag, oMemRdFlag, oModuleSel, oWtDtRam, oFirIn : filter side
//   oLoadDone, oBusy, oOverrun : status (LoadDone/Overrun are sticky)
// All outputs are registered from the current state, so they trail the
// state register by one clock.
module fir_ctrl_sequencer
  import fir_seq_pkg::*;
#(
  parameter int NUM_TAPS  = 10,
  parameter int NUM_BANKS = 4,
  parameter int COEF_W    = 16,
  parameter int IN_W      = 3
) (
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              iLoadStart,
  input  logic              iEnSample600k,
  input  logic [IN_W-1:0]   iSample,
  input  logic [1:0]        iBankSel,
  input  logic [COEF_W-1:0] iCoefData,
  output logic [5:0]        oCoefAddr,
  output logic              oCoeffUpdateFlag,
  output logic              oMemRdFlag,
  output logic [1:0]        oModuleSel,
  output logic [COEF_W-1:0] oWtDtRam,
  output logic [IN_W-1:0]   oFirIn,
  output logic              oLoadDone,
  output logic              oBusy,
  output logic              oOverrun
);

  // Position inside a bank's 20-cycle load slot where tap 0 reaches the filter.
  localparam int DATA_POS = LD_GAP_LEN + 1;

  seq_state_t      state, stateNxt;
  logic [3:0]      phase, phaseNxt;
  logic [1:0]      bankCnt, bankNxt;
  logic            doneArm;
  logic [IN_W-1:0] sampleLat;
  logic [1:0]      bankLat;

  logic            strobeOk, accept, finish, overrunSet;
  logic            inLoad, inRead, addrIssue;
  logic [4:0]      bankPos, lookPos, tapLook;

  // Next-state / counter logic
  always_comb begin
    stateNxt = state;
    phaseNxt = phase + 4'd1;
    bankNxt  = bankCnt;
    accept   = 1'b0;
    finish   = 1'b0;
    strobeOk = iEnSample600k && oLoadDone;
    unique case (state)
      IDLE: begin
        phaseNxt = '0;
        if (iLoadStart) begin
          // load wins over a same-cycle strobe; that strobe becomes an overrun
          stateNxt = LD_GAP;
          bankNxt  = '0;
        end else if (strobeOk) begin
          stateNxt = RD_FIRST;
          accept   = 1'b1;
        end
      end
      LD_GAP: if (phase == 4'(LD_GAP_LEN - 1)) begin
        stateNxt = LD_ARM;
        phaseNxt = '0;
      end
      LD_ARM: begin
        stateNxt = LD_DATA;
        phaseNxt = '0;
      end
      LD_DATA: if (phase == 4'(NUM_TAPS - 1)) begin
        stateNxt = LD_TAIL;
        phaseNxt = '0;
      end
      LD_TAIL: if (phase == 4'(LD_TAIL_LEN - 1)) begin
        phaseNxt = '0;
        if (bankCnt == 2'(NUM_BANKS - 1)) begin
          stateNxt = IDLE;
          finish   = 1'b1;
        end else begin
          stateNxt = LD_GAP;
          bankNxt  = bankCnt + 2'd1;
        end
      end
      RD_FIRST: begin
        stateNxt = RD_TAPS;
        phaseNxt = '0;
      end
      RD_TAPS: if (phase == 4'(NUM_TAPS - 1)) begin
        stateNxt = RD_TAIL;
        phaseNxt = '0;
      end
      RD_TAIL: if (phase == 4'(RD_TAIL_LEN - 1)) begin
        // last tail cycle accepts the next strobe so periodic sweeps chain
        phaseNxt = '0;
        if (strobeOk) begin
          stateNxt = RD_FIRST;
          accept   = 1'b1;
        end else begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
    overrunSet = strobeOk && !accept;
  end

  // ROM address lookahead: the address for tap k leaves ROM_LAT+1 cycles
  // before the LD_DATA cycle that consumes it (ROM latency + address reg).
  always_comb begin
    inLoad  = (state == LD_GAP) || (state == LD_ARM) ||
              (state == LD_DATA) || (state == LD_TAIL);
    inRead  = (state == RD_FIRST) || (state == RD_TAPS) || (state == RD_TAIL);
    bankPos = '0;
    unique case (state)
      LD_GAP:  bankPos = {1'b0, phase};
      LD_ARM:  bankPos = 5'(LD_GAP_LEN);
      LD_DATA: bankPos = 5'(DATA_POS) + {1'b0, phase};
      LD_TAIL: bankPos = 5'(DATA_POS + NUM_TAPS) + {1'b0, phase};
      default: bankPos = '0;
    endcase
    lookPos   = bankPos + 5'(ROM_LAT + 1);
    addrIssue = inLoad && (lookPos >= 5'(DATA_POS)) &&
                (lookPos < 5'(DATA_POS + NUM_TAPS));
    tapLook   = lookPos - 5'(DATA_POS);
  end

  // State register
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state   <= IDLE;
      phase   <= '0;
      bankCnt <= '0;
    end else begin
      state   <= stateNxt;
      phase   <= phaseNxt;
      bankCnt <= bankNxt;
    end
  end

  // Registered outputs and latches
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      doneArm          <= 1'b0;
      sampleLat        <= '0;
      bankLat          <= '0;
      oCoefAddr        <= '0;
      oCoeffUpdateFlag <= 1'b0;
      oMemRdFlag       <= 1'b0;
      oModuleSel       <= '0;
      oWtDtRam         <= '0;
      oFirIn           <= '0;
      oLoadDone        <= 1'b0;
      oBusy            <= 1'b0;
      oOverrun         <= 1'b0;
    end else begin
      doneArm <= finish;
      if (doneArm)    oLoadDone <= 1'b1;
      if (overrunSet) oOverrun  <= 1'b1;
      if (accept) begin
        sampleLat <= iSample;
        bankLat   <= iBankSel;
      end
      if (addrIssue)
        oCoefAddr <= 6'(int'(bankCnt) * NUM_TAPS + int'(tapLook));
      oBusy            <= (state != IDLE);
      oCoeffUpdateFlag <= (state == LD_ARM) || (state == LD_DATA);
      oWtDtRam         <= (state == LD_DATA) ? iCoefData : '0;
      oMemRdFlag       <= (state == RD_FIRST) || (state == RD_TAPS);
      oFirIn           <= (state == RD_FIRST) ? sampleLat : '0;
      if (inLoad)      oModuleSel <= bankCnt;
      else if (inRead) oModuleSel <= bankLat;
    end
  end

endmodule

// File: tb/tb_fir_ctrl_sequencer.sv
// Directed bench for fir_ctrl_sequencer with a ROM model and scoreboard
// queues for the coefficient-write and read/MAC streams.
module tb_fir_ctrl_sequencer;

  typedef struct packed {
    logic [15:0] val;
    logic [1:0]  sel;
  } sb_t;

  logic        iClk12M = 1'b0;
  logic        iRst = 1'b1;
  logic        iLoadStart = 1'b0;
  logic        iEnSample600k = 1'b0;
  logic [2:0]  iSample = '0;
  logic [1:0]  iBankSel = '0;
  logic [15:0] iCoefData;
  logic [5:0]  oCoefAddr;
  logic        oCoeffUpdateFlag, oMemRdFlag;
  logic [1:0]  oModuleSel;
  logic [15:0] oWtDtRam;
  logic [2:0]  oFirIn;
  logic        oLoadDone, oBusy, oOverrun;

  logic [15:0] rom [0:63];
  sb_t         cfQ[$];
  sb_t         rdQ[$];
  int          nCmp = 0;
  int          nErr = 0;

  fir_ctrl_sequencer dut (
    .iClk12M(iClk12M), .iRst(iRst), .iLoadStart(iLoadStart),
    .iEnSample600k(iEnSample600k), .iSample(iSample), .iBankSel(iBankSel),
    .iCoefData(iCoefData), .oCoefAddr(oCoefAddr),
    .oCoeffUpdateFlag(oCoeffUpdateFlag), .oMemRdFlag(oMemRdFlag),
    .oModuleSel(oModuleSel), .oWtDtRam(oWtDtRam), .oFirIn(oFirIn),
    .oLoadDone(oLoadDone), .oBusy(oBusy), .oOverrun(oOverrun)
  );

  always #5 iClk12M = ~iClk12M;

  // synchronous ROM, one cycle latency
  always @(posedge iClk12M) iCoefData <= rom[oCoefAddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCmp++;
    assert (obs === expv) else begin
      nErr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge iClk12M);
    #1;
  endtask

  task automatic pushLoad();
    for (int b = 0; b < 4; b++) begin
      cfQ.push_back('{val: 16'h0000, sel: 2'(b)});
      for (int k = 0; k < 10; k++)
        cfQ.push_back('{val: 16'(16'h0A00 + b * 16'h0100 + k), sel: 2'(b)});
    end
  endtask

  task automatic pushSweep(input logic [2:0] s, input logic [1:0] b);
    rdQ.push_back('{val: 16'(s), sel: b});
    for (int k = 0; k < 10; k++) rdQ.push_back('{val: 16'h0000, sel: b});
  endtask

  task automatic strobe(input logic [2:0] s, input logic [1:0] b);
    iSample = s; iBankSel = b; iEnSample600k = 1'b1;
    tick();
    iEnSample600k = 1'b0;
  endtask

  // pulse iLoadStart, then count clocks until oLoadDone rises
  task automatic loadAndWait(input string tag);
    int k;
    pushLoad();
    iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    k = 0;
    while (!oLoadDone && k < 200) begin
      tick();
      k++;
    end
    chk({tag, " done latency"}, k, 81);
    chk({tag, " cf queue drained"}, cfQ.size(), 0);
  endtask

  // scoreboard monitor, sampling away from the active edge
  always @(negedge iClk12M) begin
    sb_t e;
    if (oCoeffUpdateFlag || oMemRdFlag)
      chk("flags exclusive", {31'b0, oCoeffUpdateFlag & oMemRdFlag}, 0);
    if (oCoeffUpdateFlag) begin
      if (cfQ.size() == 0) chk("unexpected coef write", {16'b0, oWtDtRam}, 32'hFFFF_FFFF);
      else begin
        e = cfQ.pop_front();
        chk("wtdt", oWtDtRam, e.val);
        chk("wt modsel", oModuleSel, e.sel);
      end
    end
    if (oMemRdFlag) begin
      if (rdQ.size() == 0) chk("unexpected read", {29'b0, oFirIn}, 32'hFFFF_FFFF);
      else begin
        e = rdQ.pop_front();
        chk("firin", oFirIn, e.val);
        chk("rd modsel", oModuleSel, e.sel);
      end
    end
  end

  initial begin
    int busyCnt, rdCnt, idleCnt, k;
    for (int i = 0; i < 64; i++) rom[i] = '0;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 10; j++) rom[b * 10 + j] = 16'(16'h0A00 + b * 16'h0100 + j);

    // reset state
    tick(); tick();
    iRst = 1'b0;
    chk("rst busy", oBusy, 0);
    chk("rst loaddone", oLoadDone, 0);
    chk("rst overrun", oOverrun, 0);
    chk("rst cuf", oCoeffUpdateFlag, 0);
    chk("rst memrd", oMemRdFlag, 0);
    chk("rst addr", oCoefAddr, 0);
    chk("rst wtdt", oWtDtRam, 0);

    // strobe before load: ignored, no overrun
    strobe(3'd5, 2'd1);
    repeat (5) tick();
    chk("preload busy", oBusy, 0);
    chk("preload overrun", oOverrun, 0);

    // full load
    loadAndWait("load1");
    chk("load1 busy after", oBusy, 0);

    // single sweep
    pushSweep(3'b111, 2'd2);
    strobe(3'b111, 2'd2);
    busyCnt = 0; rdCnt = 0;
    repeat (25) begin
      tick();
      if (oBusy) busyCnt++;
      if (oMemRdFlag) rdCnt++;
    end
    chk("sweep busy cycles", busyCnt, 20);
    chk("sweep memrd cycles", rdCnt, 11);
    chk("sweep rd queue drained", rdQ.size(), 0);

    // periodic strobes every 20 clocks
    idleCnt = 0;
    for (int i = 0; i < 40; i++) begin
      pushSweep(3'(i), 2'(i));
      strobe(3'(i), 2'(i));
      if (i > 0 && !oBusy) idleCnt++;
      repeat (19) begin
        tick();
        if (!oBusy) idleCnt++;
      end
    end
    repeat (25) tick();
    chk("periodic idle gaps", idleCnt, 0);
    chk("periodic overrun", oOverrun, 0);
    chk("periodic rd queue drained", rdQ.size(), 0);

    // strobe 5 cycles into a sweep: overrun, sweep unaffected
    pushSweep(3'd5, 2'd1);
    strobe(3'd5, 2'd1);
    repeat (4) tick();
    strobe(3'd2, 2'd3);
    chk("overrun set", oOverrun, 1);
    repeat (25) tick();
    chk("overrun rd queue drained", rdQ.size(), 0);
    chk("overrun busy after", oBusy, 0);

    // reset in LD_DATA of bank 2
    pushLoad();
    iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    repeat (47) tick();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    cfQ.delete();
    chk("midrst busy", oBusy, 0);
    chk("midrst loaddone", oLoadDone, 0);
    chk("midrst overrun", oOverrun, 0);
    chk("midrst cuf", oCoeffUpdateFlag, 0);
    chk("midrst wtdt", oWtDtRam, 0);
    chk("midrst modsel", oModuleSel, 0);
    chk("midrst addr", oCoefAddr, 0);
    loadAndWait("load2");

    // load and strobe in the same IDLE cycle: load wins, overrun set
    chk("pre-collide overrun", oOverrun, 0);
    pushLoad();
    iLoadStart = 1'b1;
    iSample = 3'd6; iBankSel = 2'd0; iEnSample600k = 1'b1;
    tick();
    iLoadStart = 1'b0;
    iEnSample600k = 1'b0;
    k = 0;
    rdCnt = 0;
    while (k < 200) begin
      tick();
      k++;
      if (k == 40) chk("reload keeps loaddone", oLoadDone, 1);
      if (oMemRdFlag) rdCnt++;
      if (!oBusy) break;
    end
    chk("collide overrun", oOverrun, 1);
    chk("collide load length", k, 81);
    chk("collide no sweep", rdCnt, 0);
    chk("collide cf queue drained", cfQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/fir_ctrl_sequencer.md
# fir_ctrl_sequencer

Control sequencer that drives the reconfigurable FIR filter's coefficient-update and read/MAC interface in hardware. It sits directly in front of the filter, replacing software or bench sequencing. After a load command it loads four coefficient banks of 10 taps from an external synchronous ROM. It then runs one read/MAC sweep per 600 kHz sample strobe on a selectable bank.

## Interface
- NUM_TAPS, 10, taps per bank; fixes the length of the load and read bursts.
- NUM_BANKS, 4, coefficient banks; equals the number of oModuleSel values.
- COEF_W, 16, coefficient width.
- IN_W, 3, filter input sample width.

Ports:
- iClk12M  in  1  12 MHz clock; one clock domain.
- iRst  in  1  reset; synchronous, active-high.
- iLoadStart  in  1  single-cycle pulse that starts the full coefficient load; honoured only in IDLE.
- iEnSample600k  in  1  single-cycle sample strobe, nominally every 20 clocks.
- iSample  in  IN_W  sample value, captured when a strobe is accepted.
- iBankSel  in  2  bank used for a sweep, captured when a strobe is accepted.
- iCoefData  in  COEF_W  ROM read data, valid one cycle after oCoefAddr.
- oCoefAddr  out  6  ROM address = bank*NUM_TAPS + tap.
- oCoeffUpdateFlag  out  1  coefficient-update flag to the filter.
- oMemRdFlag  out  1  memory-read flag to the filter.
- oModuleSel  out  2  bank select to the filter.
- oWtDtRam  out  COEF_W  coefficient write data to the filter.
- oFirIn  out  IN_W  filter input.
- oLoadDone  out  1  sticky; set once all banks are loaded.
- oBusy  out  1  high in every state except IDLE.
- oOverrun  out  1  sticky; a strobe arrived while it could not be accepted.

## Operation
- All outputs are registered. Reset value of every output is 0; state returns to IDLE.
- Reset mid-burst aborts the burst immediately and clears oLoadDone and oOverrun.
- States: IDLE, LD_GAP, LD_ARM, LD_DATA, LD_TAIL, RD_FIRST, RD_TAPS, RD_TAIL.
- Load, run for each bank b = 0..NUM_BANKS-1 (20 cycles per bank):
  - LD_GAP: 4 cycles, all flags low.
  - LD_ARM: 1 cycle; oCoeffUpdateFlag=1, oWtDtRam=0.
  - LD_DATA: NUM_TAPS cycles; oCoeffUpdateFlag=1, oWtDtRam = coefficient k in cycle k.
  - LD_TAIL: 5 cycles; oCoeffUpdateFlag=0, oWtDtRam=0.
- oModuleSel = b throughout bank b's 20 cycles.
- After the last bank's LD_TAIL: set oLoadDone and go to IDLE. Total load = 80 cycles.
- ROM address for tap k is driven 2 cycles before oWtDtRam carries tap k: 1 cycle ROM latency + 1 output register. oCoefAddr holds its last value otherwise.
- Strobe acceptance requires oLoadDone=1, and the FSM must be in IDLE or the final RD_TAIL cycle.
- On acceptance, latch iSample and iBankSel, then run the read sweep:
  - RD_FIRST: 1 cycle; oMemRdFlag=1, oFirIn = latched sample.
  - RD_TAPS: NUM_TAPS cycles; oMemRdFlag=1, oFirIn=0.
  - RD_TAIL: 9 cycles; oMemRdFlag=0.
- oModuleSel = latched bank during the sweep. Sweep = 20 cycles.
- A strobe in any other state sets oOverrun and is dropped.
- A strobe before oLoadDone is ignored and does not set oOverrun.
- iLoadStart outside IDLE is ignored.
- If iLoadStart and an acceptable strobe arrive in the same IDLE cycle, the load wins and the strobe counts as an overrun.
- A reload (iLoadStart in IDLE with oLoadDone=1) keeps oLoadDone=1 during the reload.

## Timing
- Strobe at edge n puts RD_FIRST outputs on the wire after edge n+1.
- iLoadStart at edge n puts LD_GAP first cycle after edge n+1.
- Periodic strobes every 20 cycles chain back-to-back with no idle cycle, because the final RD_TAIL cycle accepts the next strobe.
- oCoeffUpdateFlag and oMemRdFlag are never high in the same cycle.

## Structure
- Package fir_seq_pkg holds:
  - state enum;
  - constants LD_GAP_LEN=4, LD_TAIL_LEN=5, RD_TAIL_LEN=9, ROM_LAT=1.
- Single module with a phase counter and a bank counter; no sub-module.

## Test plan
- Load: ROM[b*10+k] = 16'h0A00 + b*16'h0100 + k; pulse iLoadStart -> per bank, 10 consecutive oWtDtRam values 0x0A00..0x0A09 (bank 0) through 0x0D00..0x0D09 (bank 3), each with oCoeffUpdateFlag=1 and the correct oModuleSel; oLoadDone rises 81 cycles after the pulse.
- Single sweep: iSample=3'b111, iBankSel=2 -> oFirIn=111 for 1 cycle, then 0; oMemRdFlag high 11 cycles; oModuleSel=2; oBusy high 20 cycles.
- Periodic strobes every 20 cycles for 40 samples, cycling banks 0..3 -> continuous sweeps, oOverrun stays 0.
- Strobe 5 cycles into a sweep -> oOverrun=1, sweep unaffected; strobe before load -> no sweep, oOverrun=0.
- iRst asserted in the middle of LD_DATA of bank 2 -> next cycle all outputs 0, oLoadDone=0; a new load completes normally.
- iLoadStart and strobe in the same IDLE cycle after load -> load runs, oOverrun=1.
